// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared types and constants for the pooling-array arbiter
package pool_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam logic [2:0] DIM_3 = 3'd3;
  localparam logic [2:0] DIM_4 = 3'd4;
  localparam logic [2:0] DIM_5 = 3'd5;

  localparam int DEFAULT_TIMEOUT = 64;
  localparam int CNT_W           = 7;

  function automatic logic dim_valid(input logic [2:0] dim);
    return (dim == DIM_3) || (dim == DIM_4) || (dim == DIM_5);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting just after the last winner
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LW      = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [LW-1:0]      last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               valid_o
);

  logic [LW-1:0] idx;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    // Offset 1..NUM_REQ so the previous winner is considered last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = LW'((int'(last_i) + i) % NUM_REQ);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pool_arb.sv
// rtl/pool_arb.sv - round-robin owner arbitration for the shared pooling array
module pool_arb
  import pool_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0][2:0] req_inst,
  input  logic [NUM_REQ-1:0][2:0] req_dim,
  input  logic                    pu_done,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      job_done,
  output logic                    start_pool,
  output logic [2:0]              pooling_inst,
  output logic [2:0]              array_dim,
  output logic                    busy,
  output logic                    timeout_err,
  output logic                    dim_err
);

  localparam int              LW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q;
  logic [LW-1:0]      last_q;
  logic [LW-1:0]      win_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] job_done_q;
  logic               start_q;
  logic [2:0]         inst_q;
  logic [2:0]         dim_q;
  logic               busy_q;
  logic               tmo_q;
  logic               dim_err_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_valid;
  logic [LW-1:0]      arb_idx;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .LW     (LW)
  ) u_rr (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .valid_o(arb_valid)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) arb_idx = LW'(i);
    end
  end

  // Outputs are registered alongside the state so they track it cycle for cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      last_q     <= LW'(NUM_REQ - 1);
      win_q      <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      job_done_q <= '0;
      start_q    <= 1'b0;
      inst_q     <= '0;
      dim_q      <= '0;
      busy_q     <= 1'b0;
      tmo_q      <= 1'b0;
      dim_err_q  <= 1'b0;
    end else begin
      start_q    <= 1'b0;
      job_done_q <= '0;
      tmo_q      <= 1'b0;
      dim_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            win_q   <= arb_idx;
            inst_q  <= req_inst[arb_idx];
            dim_q   <= req_dim[arb_idx];
            grant_q <= arb_gnt;
            busy_q  <= 1'b1;
            if (dim_valid(req_dim[arb_idx])) begin
              state_q <= ST_ISSUE;
              start_q <= 1'b1;
            end else begin
              state_q    <= ST_RELEASE;
              job_done_q <= arb_gnt;
              dim_err_q  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
          cnt_q   <= '0;
        end
        ST_WAIT: begin
          // pu_done is tested first so it wins a tie with the timeout.
          if (pu_done) begin
            state_q    <= ST_RELEASE;
            job_done_q <= grant_q;
          end else if (cnt_q == CNT_LAST) begin
            state_q    <= ST_RELEASE;
            job_done_q <= grant_q;
            tmo_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          state_q <= ST_IDLE;
          last_q  <= win_q;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant        = grant_q;
  assign job_done     = job_done_q;
  assign start_pool   = start_q;
  assign pooling_inst = inst_q;
  assign array_dim    = dim_q;
  assign busy         = busy_q;
  assign timeout_err  = tmo_q;
  assign dim_err      = dim_err_q;

endmodule

// File: tb/tb_pool_arb.sv
// tb/tb_pool_arb.sv - self-checking bench for pool_arb
module tb_pool_arb;

  localparam int N   = 4;
  localparam int TMO = 64;

  logic              clk = 1'b0;
  logic              nrst;
  logic [N-1:0]      req;
  logic [N-1:0][2:0] req_inst;
  logic [N-1:0][2:0] req_dim;
  logic              pu_done;
  logic [N-1:0]      grant;
  logic [N-1:0]      job_done;
  logic              start_pool;
  logic [2:0]        pooling_inst;
  logic [2:0]        array_dim;
  logic              busy;
  logic              timeout_err;
  logic              dim_err;

  pool_arb #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .nrst(nrst), .req(req), .req_inst(req_inst), .req_dim(req_dim),
    .pu_done(pu_done), .grant(grant), .job_done(job_done), .start_pool(start_pool),
    .pooling_inst(pooling_inst), .array_dim(array_dim), .busy(busy),
    .timeout_err(timeout_err), .dim_err(dim_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int m_last;

  int           o_start, o_done, o_nstart;
  logic [N-1:0] o_grant, o_done_vec;
  logic         o_tmo, o_derr, o_idle_after;
  logic [2:0]   o_inst, o_dim;

  // Round-robin reference: first requester after the previous winner, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (((r >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  // Expected job_done cycle, counting the IDLE request cycle as 0.
  function automatic int exp_done_cycle(input bit valid_dim, input int d);
    if (!valid_dim) return 1;
    if (d >= 1 && d <= TMO) return 1 + d + 1;
    return 1 + TMO + 1;
  endfunction

  task automatic apply_reset();
    nrst = 1'b0; req = '0; pu_done = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    m_last = N - 1;
  endtask

  // Drives one job and records what the DUT did; pu_delay is cycles after start_pool, -1 = never.
  task automatic run_job(input logic [N-1:0] r, input int pu_delay, input bit drop_req);
    int cyc;
    bit done;
    req = r; cyc = 0; done = 0;
    o_start = -1; o_done = -1; o_nstart = 0; o_grant = '0; o_done_vec = '0;
    o_tmo = 1'b0; o_derr = 1'b0; o_inst = '0; o_dim = '0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (start_pool) begin
        o_nstart++;
        if (o_start < 0) o_start = cyc;
      end
      if (grant != '0 && o_grant == '0) begin
        o_grant = grant; o_inst = pooling_inst; o_dim = array_dim;
      end
      if (job_done != '0) begin
        o_done = cyc; o_done_vec = job_done; o_tmo = timeout_err; o_derr = dim_err; done = 1;
      end
      pu_done = (o_start > 0 && pu_delay >= 0 && cyc == o_start + pu_delay);
      if (drop_req && cyc == 1) req = '0;
    end
    pu_done = 1'b0;
    @(negedge clk);
    o_idle_after = (busy == 1'b0 && grant == '0 && job_done == '0 && start_pool == 1'b0);
  endtask

  task automatic test_reset();
    req = '0; pu_done = 1'b0; req_inst = '0; req_dim = '0;
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({grant, job_done, start_pool, busy, timeout_err, dim_err} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0", {grant, job_done, start_pool, busy, timeout_err, dim_err});
    end
    checks++;
    if ({pooling_inst, array_dim} !== 6'd0) begin
      errors++; $display("FAIL reset_data: got %b want 0", {pooling_inst, array_dim});
    end
    nrst = 1'b1;
    m_last = N - 1;
  endtask

  task automatic test_single_job();
    req_inst[0] = 3'b100; req_dim[0] = 3'd5;
    run_job(4'b0001, 10, 1'b0);
    req = '0;
    checks++;
    if (o_start !== 1) begin errors++; $display("FAIL single_start: got %0d want 1", o_start); end
    checks++;
    if (o_grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", o_grant); end
    checks++;
    if (o_done !== exp_done_cycle(1, 10) || o_done_vec !== 4'b0001) begin
      errors++; $display("FAIL single_done: got cyc %0d vec %b want cyc %0d vec 0001", o_done, o_done_vec, exp_done_cycle(1, 10));
    end
    checks++;
    if (o_dim !== 3'd5 || o_inst !== 3'b100 || o_tmo !== 1'b0) begin
      errors++; $display("FAIL single_latch: got dim %0d inst %b tmo %b want 5 100 0", o_dim, o_inst, o_tmo);
    end
    checks++;
    if (!o_idle_after || array_dim !== 3'd5 || pooling_inst !== 3'b100) begin
      errors++; $display("FAIL single_hold: got idle %b dim %0d inst %b want 1 5 100", o_idle_after, array_dim, pooling_inst);
    end
    m_last = 0;
  endtask

  task automatic test_fairness();
    logic [N-1:0] want;
    apply_reset();
    for (int i = 0; i < N; i++) begin req_dim[i] = 3'd4; req_inst[i] = 3'($urandom_range(0, 7)); end
    for (int j = 0; j < 8; j++) begin
      run_job(4'b1111, int'($urandom_range(1, 5)), 1'b0);
      want = N'(1) << (j % N);
      checks++;
      if (o_grant !== want || o_done_vec !== want) begin
        errors++; $display("FAIL fair_order job %0d: got grant %b done %b want %b", j, o_grant, o_done_vec, want);
      end
      m_last = j % N;
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    req_dim[2] = 3'd4;
    run_job(4'b0100, -1, 1'b0);
    req = '0;
    checks++;
    if (o_done !== 1 + TMO + 1 || o_tmo !== 1'b1 || o_done_vec !== 4'b0100) begin
      errors++; $display("FAIL timeout: got cyc %0d tmo %b vec %b want cyc %0d tmo 1 vec 0100", o_done, o_tmo, o_done_vec, 1 + TMO + 1);
    end
    checks++;
    if (!o_idle_after) begin errors++; $display("FAIL timeout_idle: got busy %b want 0", busy); end
    m_last = 2;
  endtask

  task automatic test_invalid_dim();
    req_dim[1] = 3'd6;
    run_job(4'b0010, 3, 1'b0);
    req = '0;
    checks++;
    if (o_nstart !== 0) begin errors++; $display("FAIL dim_nostart: got %0d starts want 0", o_nstart); end
    checks++;
    if (o_done !== 1 || o_derr !== 1'b1 || o_done_vec !== 4'b0010 || o_grant !== 4'b0010) begin
      errors++; $display("FAIL dim_err: got cyc %0d derr %b vec %b grant %b want 1 1 0010 0010", o_done, o_derr, o_done_vec, o_grant);
    end
    m_last = 1;
  endtask

  task automatic test_collision();
    req_dim[0] = 3'd3;
    run_job(4'b0001, TMO, 1'b0);
    req = '0;
    checks++;
    if (o_done !== 1 + TMO + 1 || o_tmo !== 1'b0 || o_done_vec !== 4'b0001) begin
      errors++; $display("FAIL collision: got cyc %0d tmo %b vec %b want cyc %0d tmo 0 vec 0001", o_done, o_tmo, o_done_vec, 1 + TMO + 1);
    end
    m_last = 0;
  endtask

  task automatic test_idle_pu_done();
    pu_done = 1'b1;
    @(negedge clk);
    pu_done = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || job_done !== '0 || start_pool !== 1'b0) begin
      errors++; $display("FAIL idle_pu: got busy %b done %b start %b want 0 0 0", busy, job_done, start_pool);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    req_dim[0] = 3'd4; req_dim[3] = 3'd5;
    req = 4'b0001;
    repeat (5) @(negedge clk);
    nrst = 1'b0;
    #1;
    checks++;
    if ({grant, job_done, start_pool, busy, timeout_err, dim_err, pooling_inst, array_dim} !== '0) begin
      errors++; $display("FAIL rst_mid: got %b want 0", {grant, job_done, start_pool, busy, timeout_err, dim_err, pooling_inst, array_dim});
    end
    req = '0;
    seen = 0;
    repeat (3) begin @(negedge clk); if (job_done != '0) seen = 1; end
    checks++;
    if (seen) begin errors++; $display("FAIL rst_nodone: got job_done pulse want none"); end
    nrst = 1'b1;
    m_last = N - 1;
    run_job(4'b1000, 4, 1'b0);
    req = '0;
    checks++;
    if (o_grant !== 4'b1000 || o_done !== exp_done_cycle(1, 4)) begin
      errors++; $display("FAIL rst_after: got grant %b cyc %0d want 1000 %0d", o_grant, o_done, exp_done_cycle(1, 4));
    end
    m_last = 3;
  endtask

  task automatic test_random();
    logic [N-1:0] r, want;
    logic [1:0]   wi;
    int d, w, sel, exp_done;
    bit drop, vdim;
    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < N; i++) begin
        req_inst[i] = 3'($urandom_range(0, 7));
        req_dim[i]  = 3'($urandom_range(2, 6));
      end
      r = N'($urandom_range(1, (1 << N) - 1));
      sel = int'($urandom_range(0, 9));
      if (sel == 0) d = -1;
      else if (sel == 1) d = TMO - 1 + int'($urandom_range(0, 2));
      else d = int'($urandom_range(0, 12));
      drop = ($urandom_range(0, 3) == 0);
      w = rr_pick(r, m_last);
      wi = 2'(w);
      want = N'(1) << w;
      vdim = (req_dim[wi] >= 3'd3 && req_dim[wi] <= 3'd5);
      exp_done = exp_done_cycle(vdim, d);
      run_job(r, d, drop);
      req = '0;
      checks++;
      if (o_grant !== want || o_done_vec !== want || o_inst !== req_inst[wi] || o_dim !== req_dim[wi]) begin
        errors++;
        $display("FAIL rand_owner job %0d: got grant %b done %b inst %b dim %0d want %b %b %b %0d",
                 j, o_grant, o_done_vec, o_inst, o_dim, want, want, req_inst[wi], req_dim[wi]);
      end
      checks++;
      if (o_done !== exp_done || o_nstart !== (vdim ? 1 : 0) || o_derr !== !vdim ||
          o_tmo !== (vdim && !(d >= 1 && d <= TMO)) || !o_idle_after) begin
        errors++;
        $display("FAIL rand_flow job %0d: got cyc %0d starts %0d derr %b tmo %b idle %b want cyc %0d d=%0d vdim %b",
                 j, o_done, o_nstart, o_derr, o_tmo, o_idle_after, exp_done, d, vdim);
      end
      m_last = w;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_job();
    test_fairness();
    test_timeout();
    test_invalid_dim();
    test_collision();
    test_idle_pu_done();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
